// File: rtl/trig_sync_pkg.sv
// Shared defaults and helpers for the multi-channel trigger synchroniser.
// Latency: none, constants and functions only.
// Backpressure: none.
package trig_sync_pkg;
  localparam int N_CH_DEF        = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 12;
  localparam int DEAD_W_DEF      = 4;

  // Channel-index width; at least one bit so a single-channel build keeps a ts_ch port.
  function automatic int ch_idx_w(input int n_ch);
    return (n_ch <= 1) ? 1 : $clog2(n_ch);
  endfunction
endpackage

// File: rtl/trig_sync_mc_if.sv
// Timestamp record stream: valid/ready handshake carrying channel index and coarse time.
// Latency: none, wires only.
// Backpressure: the producer holds the record while ts_valid=1 and ts_ready=0.
interface trig_sync_mc_if
  import trig_sync_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();
  localparam int CH_W = ch_idx_w(N_CH);

  logic            ts_valid;
  logic            ts_ready;
  logic [CH_W-1:0] ts_ch;
  logic [CNT_W-1:0] ts_value;

  modport master (output ts_valid, output ts_ch, output ts_value, input ts_ready);
  modport slave  (input ts_valid, input ts_ch, input ts_value, output ts_ready);
endinterface

// File: rtl/trig_sync_ch.sv
// One trigger channel: dual-edge first stage, rising-clock sync chain, edge detect, hold-off.
// Latency: SYNC_STAGES cycles (rising path) or SYNC_STAGES-0.5 (falling path) to sync_lvl.
// Backpressure: none; pulses are suppressed only by ch_en and the hold-off counter.
module trig_sync_ch
  import trig_sync_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEAD_W      = DEAD_W_DEF
) (
  input  logic              sync_clk,
  input  logic              rst_n,
  input  logic              trig_in,
  input  logic              phase_sel,
  input  logic              ch_en,
  input  logic [DEAD_W-1:0] dead_time,
  output logic              sync_lvl,
  output logic              trig_pulse
);
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [SYNC_STAGES-2:0] chain_q, chain_d;
  logic                   prev_q, prev_d;
  logic [DEAD_W-1:0]      dead_q, dead_d;

  // Both first-stage flops sample the raw asynchronous input.
  always_comb begin
    rise_d = trig_in;
    fall_d = trig_in;
  end

  // Rising-edge first stage.
  always_ff @(posedge sync_clk or negedge rst_n) begin
    if (!rst_n) rise_q <= 1'b0;
    else        rise_q <= rise_d;
  end

  // Falling-edge first stage; gains half a cycle when selected.
  always_ff @(negedge sync_clk or negedge rst_n) begin
    if (!rst_n) fall_q <= 1'b0;
    else        fall_q <= fall_d;
  end

  // Remaining stages shift on rising edges; the mux swaps sources without flushing the chain.
  always_comb begin
    chain_d    = chain_q;
    chain_d[0] = phase_sel ? fall_q : rise_q;
    for (int k = 1; k < SYNC_STAGES - 1; k++) chain_d[k] = chain_q[k-1];
  end

  assign sync_lvl   = chain_q[SYNC_STAGES-2];
  assign trig_pulse = sync_lvl & ~prev_q & ch_en & (dead_q == '0);

  // Hold-off: load on a pulse, count down to zero, forced clear while disabled.
  always_comb begin
    prev_d = sync_lvl;
    dead_d = dead_q;
    if (!ch_en)               dead_d = '0;
    else if (trig_pulse)      dead_d = dead_time;
    else if (dead_q != '0)    dead_d = dead_q - DEAD_W'(1);
  end

  // Chain, edge-detect history and hold-off state.
  always_ff @(posedge sync_clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
      dead_q  <= '0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
      dead_q  <= dead_d;
    end
  end
endmodule

// File: rtl/trig_sync_mc.sv
// Multi-channel trigger synchroniser with per-channel pending timestamps and round-robin output.
// Latency: trig_pulse to ts_valid is 2 cycles with an empty slot and no contention.
// Backpressure: output slot holds under ts_ready=0; one pending record per channel, extra pulses dropped and flagged.
module trig_sync_mc
  import trig_sync_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEAD_W      = DEAD_W_DEF
) (
  input  logic              sync_clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   trig_in,
  input  logic [N_CH-1:0]   phase_sel,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [DEAD_W-1:0] dead_time,
  input  logic              clr_ovf,
  output logic [N_CH-1:0]   sync_lvl,
  output logic [N_CH-1:0]   trig_pulse,
  output logic              overflow,
  trig_sync_mc_if.master    ts
);
  localparam int CH_W = ch_idx_w(N_CH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0] pval_q [N_CH];
  logic [CNT_W-1:0] pval_d [N_CH];
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic             slot_vld_q, slot_vld_d;
  logic [CH_W-1:0]  slot_ch_q, slot_ch_d;
  logic [CNT_W-1:0] slot_val_q, slot_val_d;
  logic             ovf_q, ovf_d;
  logic             ovf_set;
  logic             gnt_vld, load, take;
  logic [CH_W-1:0]  gnt_idx, cand;
  logic [N_CH-1:0]  take_vec;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    trig_sync_ch #(.SYNC_STAGES(SYNC_STAGES), .DEAD_W(DEAD_W)) u_ch (
      .sync_clk   (sync_clk),
      .rst_n      (rst_n),
      .trig_in    (trig_in[g]),
      .phase_sel  (phase_sel[g]),
      .ch_en      (ch_en[g]),
      .dead_time  (dead_time),
      .sync_lvl   (sync_lvl[g]),
      .trig_pulse (trig_pulse[g])
    );
  end

  // Round-robin search from the pointer; the slot accepts when empty or being drained.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    for (int off = 0; off < N_CH; off++) begin
      cand = CH_W'((int'(ptr_q) + off) % N_CH);
      if (!gnt_vld && pend_q[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    load     = !slot_vld_q || ts.ts_ready;
    take     = load && gnt_vld;
    take_vec = '0;
    if (take) take_vec[gnt_idx] = 1'b1;
  end

  // Pending slots: a pulse refills a slot being drained this cycle, otherwise a full slot drops it.
  always_comb begin
    pend_d  = pend_q;
    pval_d  = pval_q;
    ovf_set = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (trig_pulse[i]) begin
        if (pend_q[i] && !take_vec[i]) begin
          ovf_set = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          pval_d[i] = cnt_q;
        end
      end else if (take_vec[i]) begin
        pend_d[i] = 1'b0;
      end
    end
    ovf_d = ovf_set | (ovf_q & ~clr_ovf);
    cnt_d = cnt_q + CNT_W'(1);
  end

  // Output slot and pointer update.
  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_ch_d  = slot_ch_q;
    slot_val_d = slot_val_q;
    ptr_d      = ptr_q;
    if (load) begin
      slot_vld_d = gnt_vld;
      if (gnt_vld) begin
        slot_ch_d  = gnt_idx;
        slot_val_d = pval_q[gnt_idx];
        ptr_d      = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
      end
    end
  end

  // Shared state registers.
  always_ff @(posedge sync_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      pend_q     <= '0;
      for (int i = 0; i < N_CH; i++) pval_q[i] <= '0;
      ptr_q      <= '0;
      slot_vld_q <= 1'b0;
      slot_ch_q  <= '0;
      slot_val_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pval_q     <= pval_d;
      ptr_q      <= ptr_d;
      slot_vld_q <= slot_vld_d;
      slot_ch_q  <= slot_ch_d;
      slot_val_q <= slot_val_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ts.ts_valid = slot_vld_q;
  assign ts.ts_ch    = slot_ch_q;
  assign ts.ts_value = slot_val_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_trig_sync_mc.sv
// Bench for trig_sync_mc: directed vector table, corner sequences and random traffic vs a reference model.
// Latency: inputs driven 1 unit after each rising edge, outputs sampled 1 unit later.
// Backpressure: ts_ready is driven directly on the interface instance.
module tb_trig_sync_mc;
  localparam int N  = 4;
  localparam int S  = 2;
  localparam int CW = 12;
  localparam int DW = 4;

  logic          sync_clk = 1'b0;
  logic          rst_n    = 1'b0;
  logic [N-1:0]  trig_in  = '0;
  logic [N-1:0]  phase_sel = '0;
  logic [N-1:0]  ch_en    = '0;
  logic [DW-1:0] dead_time = '0;
  logic          clr_ovf  = 1'b0;
  logic [N-1:0]  sync_lvl, trig_pulse;
  logic          overflow;

  trig_sync_mc_if #(.N_CH(N), .CNT_W(CW)) ts_if ();

  trig_sync_mc #(.N_CH(N), .SYNC_STAGES(S), .CNT_W(CW), .DEAD_W(DW)) dut (
    .sync_clk   (sync_clk),
    .rst_n      (rst_n),
    .trig_in    (trig_in),
    .phase_sel  (phase_sel),
    .ch_en      (ch_en),
    .dead_time  (dead_time),
    .clr_ovf    (clr_ovf),
    .sync_lvl   (sync_lvl),
    .trig_pulse (trig_pulse),
    .overflow   (overflow),
    .ts         (ts_if)
  );

  always #5 sync_clk = ~sync_clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: cycle-indexed history of inputs, hold-off as "earliest allowed cycle".
  int           m_n;
  logic [N-1:0] m_trig_h [16];
  logic [N-1:0] m_ps_h   [16];
  logic [N-1:0] m_prev, m_lvl, m_pulse, m_pend;
  int           m_next_ok [N];
  int           m_pval    [N];
  logic         m_vld, m_ovf;
  int           m_ch, m_val, m_ptr, m_cnt;

  function automatic logic trig_at(input int c, input int i);
    if (c < 0) return 1'b0;
    return m_trig_h[c % 16][i];
  endfunction

  function automatic logic ps_at(input int c, input int i);
    if (c < 0) return 1'b0;
    return m_ps_h[c % 16][i];
  endfunction

  task automatic model_reset();
    m_n = 0; m_prev = '0; m_lvl = '0; m_pulse = '0; m_pend = '0;
    m_vld = 1'b0; m_ovf = 1'b0; m_ch = 0; m_val = 0; m_ptr = 0; m_cnt = 0;
    for (int k = 0; k < 16; k++) begin m_trig_h[k] = '0; m_ps_h[k] = '0; end
    for (int i = 0; i < N; i++) begin m_next_ok[i] = 0; m_pval[i] = 0; end
  endtask

  task automatic step(input logic [N-1:0] t, input logic [N-1:0] ps, input logic [N-1:0] en,
                      input logic [DW-1:0] dt, input logic rdy, input logic clr);
    int  w, st, old_val;
    logic load, ovf_set;
    @(posedge sync_clk); #1;
    rst_n = 1'b1; trig_in = t; phase_sel = ps; ch_en = en; dead_time = dt;
    ts_if.ts_ready = rdy; clr_ovf = clr;
    #1;
    m_trig_h[m_n % 16] = t;
    m_ps_h[m_n % 16]   = ps;
    st = m_n - (S - 2);
    for (int i = 0; i < N; i++) begin
      m_lvl[i]   = ps_at(st - 1, i) ? trig_at(st - 1, i) : trig_at(st - 2, i);
      m_pulse[i] = m_lvl[i] & ~m_prev[i] & en[i] & (m_n >= m_next_ok[i]);
    end
    chk("mdl_sync_lvl", 32'(sync_lvl), 32'(m_lvl));
    chk("mdl_trig_pulse", 32'(trig_pulse), 32'(m_pulse));
    chk("mdl_ts_valid", 32'(ts_if.ts_valid), 32'(m_vld));
    if (m_vld) begin
      chk("mdl_ts_ch", 32'(ts_if.ts_ch), m_ch);
      chk("mdl_ts_value", 32'(ts_if.ts_value), m_val);
    end
    chk("mdl_overflow", 32'(overflow), 32'(m_ovf));
    load = !m_vld || rdy;
    w = -1;
    if (load)
      for (int k = 0; k < N; k++)
        if (w < 0 && m_pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    old_val = (w >= 0) ? m_pval[w] : 0;
    ovf_set = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_pulse[i]) begin
        m_next_ok[i] = m_n + int'(dt) + 1;
        if (m_pend[i] && w != i) ovf_set = 1'b1;
        else begin m_pend[i] = 1'b1; m_pval[i] = m_cnt; end
      end else if (w == i) begin
        m_pend[i] = 1'b0;
      end
      if (!en[i]) m_next_ok[i] = m_n + 1;
    end
    if (load) begin
      m_vld = (w >= 0);
      if (w >= 0) begin m_ch = w; m_val = old_val; m_ptr = (w + 1) % N; end
    end
    m_ovf  = ovf_set || (m_ovf && !clr);
    m_prev = m_lvl;
    m_cnt  = (m_cnt + 1) % (1 << CW);
    m_n++;
  endtask

  task automatic idle(input int cycles, input logic rdy);
    for (int k = 0; k < cycles; k++) step('0, '0, '1, '0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge sync_clk); #1;
    rst_n = 1'b0; trig_in = '0; phase_sel = '0; ch_en = '0; dead_time = '0;
    ts_if.ts_ready = 1'b0; clr_ovf = 1'b0;
    #1;
    chk("rst_sync_lvl", 32'(sync_lvl), 0);
    chk("rst_trig_pulse", 32'(trig_pulse), 0);
    chk("rst_ts_valid", 32'(ts_if.ts_valid), 0);
    chk("rst_ts_ch", 32'(ts_if.ts_ch), 0);
    chk("rst_ts_value", 32'(ts_if.ts_value), 0);
    chk("rst_overflow", 32'(overflow), 0);
    model_reset();
    repeat (2) @(posedge sync_clk);
  endtask

  typedef struct {
    logic [N-1:0] trig, ps, lvl, pulse;
    logic         vld;
    int           ch, val;
  } vec_t;

  function automatic vec_t mk(input logic [N-1:0] t, input logic [N-1:0] p, input logic [N-1:0] l,
                              input logic [N-1:0] pu, input logic v, input int c, input int x);
    vec_t r;
    r.trig = t; r.ps = p; r.lvl = l; r.pulse = pu; r.vld = v; r.ch = c; r.val = x;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [18];
    int   pcyc [$];
    int   vals [$];
    int   rch  [$];
    int   guard;
    logic [N-1:0]  rt, rps, ren;

    ts_if.ts_ready = 1'b0;
    // All four channels at once (ptr starts at 0), then ch0 via falling path, then ch0 via rising path.
    tbl[0]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0);
    tbl[1]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0);
    tbl[2]  = mk(4'b0000, 4'b0000, 4'b1111, 4'b1111, 1'b0, 0, 0);
    tbl[3]  = mk(4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 0, 0);
    tbl[4]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 0, 2);
    tbl[5]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1, 2);
    tbl[6]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2, 2);
    tbl[7]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 3, 2);
    tbl[8]  = mk(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 0, 0);
    tbl[9]  = mk(4'b0000, 4'b0001, 4'b0001, 4'b0001, 1'b0, 0, 0);
    tbl[10] = mk(4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 0, 0);
    tbl[11] = mk(4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1, 0, 9);
    tbl[12] = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0);
    tbl[13] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0);
    tbl[14] = mk(4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0, 0, 0);
    tbl[15] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0);
    tbl[16] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 0, 14);
    tbl[17] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 0);

    do_reset();
    for (int k = 0; k < 18; k++) begin
      step(tbl[k].trig, tbl[k].ps, 4'hF, 4'd0, 1'b1, 1'b0);
      chk($sformatf("tbl%0d_sync_lvl", k), 32'(sync_lvl), 32'(tbl[k].lvl));
      chk($sformatf("tbl%0d_trig_pulse", k), 32'(trig_pulse), 32'(tbl[k].pulse));
      chk($sformatf("tbl%0d_ts_valid", k), 32'(ts_if.ts_valid), 32'(tbl[k].vld));
      if (tbl[k].vld) begin
        chk($sformatf("tbl%0d_ts_ch", k), 32'(ts_if.ts_ch), tbl[k].ch);
        chk($sformatf("tbl%0d_ts_value", k), 32'(ts_if.ts_value), tbl[k].val);
      end
      chk($sformatf("tbl%0d_overflow", k), 32'(overflow), 0);
    end

    // Hold-off of 3: level edges 2 cycles apart collapse to one pulse, the one 4 cycles later passes.
    for (int k = 0; k < 12; k++) begin
      step((k < 5 && k % 2 == 0) ? 4'b0010 : 4'b0000, '0, 4'hF, 4'd3, 1'b1, 1'b0);
      if (trig_pulse[1]) pcyc.push_back(k);
    end
    chk("dead_pulse_count", pcyc.size(), 2);
    if (pcyc.size() == 2) chk("dead_pulse_spacing", pcyc[1] - pcyc[0], 4);

    // Stalled consumer: first record in slot, second pending, third dropped.
    for (int k = 0; k < 10; k++)
      step((k < 5 && k % 2 == 0) ? 4'b0100 : 4'b0000, '0, 4'hF, 4'd0, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_slot_vld", 32'(ts_if.ts_valid), 1);
    chk("ovf_slot_ch", 32'(ts_if.ts_ch), 2);
    step('0, '0, 4'hF, 4'd0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step('0, '0, 4'hF, 4'd0, 1'b1, 1'b0);
      if (k == 0) chk("ovf_cleared", 32'(overflow), 0);
      if (ts_if.ts_valid) vals.push_back(int'(ts_if.ts_value));
    end
    chk("ovf_records", vals.size(), 2);
    if (vals.size() == 2) chk("ovf_record_spacing", vals[1] - vals[0], 2);

    // Counter wrap: ch0 pulses at 4095, ch1 one cycle later at 0.
    guard = 0;
    while (m_cnt != 4093 && guard < 5000) begin
      step('0, '0, 4'hF, 4'd0, 1'b1, 1'b0);
      guard++;
    end
    step(4'b0001, '0, 4'hF, 4'd0, 1'b1, 1'b0);
    step(4'b0010, '0, 4'hF, 4'd0, 1'b1, 1'b0);
    vals.delete();
    for (int k = 0; k < 8; k++) begin
      step('0, '0, 4'hF, 4'd0, 1'b1, 1'b0);
      if (ts_if.ts_valid) begin
        vals.push_back(int'(ts_if.ts_value));
        rch.push_back(int'(ts_if.ts_ch));
      end
    end
    chk("wrap_records", vals.size(), 2);
    if (vals.size() == 2) begin
      chk("wrap_first_val", vals[0], 4095);
      chk("wrap_first_ch", rch[0], 0);
      chk("wrap_second_val", vals[1], 0);
      chk("wrap_second_ch", rch[1], 1);
    end

    // Reset with a record in the slot and another pending: both must vanish.
    step(4'b1000, '0, 4'hF, 4'd0, 1'b0, 1'b0);
    step(4'b0000, '0, 4'hF, 4'd0, 1'b0, 1'b0);
    step(4'b1000, '0, 4'hF, 4'd0, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("pre_rst_vld", 32'(ts_if.ts_valid), 1);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step('0, '0, 4'hF, 4'd0, 1'b1, 1'b0);
      chk("post_rst_vld", 32'(ts_if.ts_valid), 0);
    end

    // Random traffic against the model.
    rt = '0; rps = '0;
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) do_reset();
      rt = rt ^ (N'($urandom) & N'($urandom));
      if ($urandom_range(0, 19) == 0) rps = N'($urandom);
      ren = ($urandom_range(0, 9) == 0) ? N'($urandom) : 4'hF;
      step(rt, rps, ren, DW'($urandom_range(0, 4)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
